decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline.
- Decodes the IF/ID instruction, drives the register-file read addresses, and applies a write-through bypass from writeback.
- Detects load-use hazards and produces the registered ID/EX pipeline bundle that feeds the execute stage.
- Register-file read data arrives combinationally; all outputs except A1/A2/StallD are registered.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PC+4 of InstrD
- ValidD  in  1  IF/ID holds a real instruction
- A1  out  5  rs1 read address (InstrD[19:15])
- A2  out  5  rs2 read address (InstrD[24:20])
- RD1  in  32  regfile read data 1
- RD2  in  32  regfile read data 2
- RegWriteW  in  1  writeback write enable
- RDW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  branch/jump taken; squash ID/EX
- StallD  out  1  load-use stall request (combinational) to IF/ID and PC
- RD1E, RD2E  out  32 each  operand data
- ImmExtE  out  32  sign-extended immediate
- PCE, PCPlus4E  out  32 each  PC bundle
- RS1E, RS2E, RDE  out  5 each  register indices
- RegWriteE  out  1  register write enable
- MemWriteE  out  1  memory write enable
- ResultSrcE  out  2  result source: 00 ALU, 01 mem, 10 PC+4
- ALUSrcE  out  1  ALU source: 0 reg, 1 imm
- BranchE  out  1  branch
- JumpE  out  1  jump
- ALUControlE  out  3  ALU operation
- ValidE  out  1  valid
- IllegalE  out  1  illegal opcode seen

Behaviour:
- Reset (rst==0 at posedge): every registered output is 0 (a bubble).
  - Reset wins over FlushE and stall.
  - StallD is forced 0 while rst==0.
- Decoded opcodes:
  - 0000011 lw: I-imm, ALUSrc=1, ResultSrc=01, RegWrite=1.
  - 0100011 sw: S-imm, ALUSrc=1, MemWrite=1.
  - 0110011 R-type.
  - 0010011 I-ALU: I-imm, ALUSrc=1, RegWrite=1.
  - 1100011 beq: B-imm, Branch=1, ALU sub.
  - 1101111 jal: J-imm, Jump=1, ResultSrc=10, RegWrite=1.
  - Any other opcode with ValidD=1: all enables 0, IllegalE=1, ValidE=1.
- ALUControl encoding:
  - 000 add (lw, sw, addi, add with funct7[5]=0)
  - 001 sub (R-type with funct7[5]=1; beq)
  - 010 and
  - 011 or
  - 101 slt
  - 100 xor
  - Selected by funct3 as 111/110/010/100.
  - Unsupported funct3 values map to add.
- Immediates: all sign-extended from InstrD[31]; bit 0 of B and J immediates is 0.
- Bypass: if RegWriteW && RDW!=0 && RDW==A1, then RD1E captures ResultW, not RD1. Same rule for A2/RD2. This covers the regfile's write-at-edge / read-before-write timing.
- Load-use: StallD = ValidE && ResultSrcE==01 && RegWriteE && RDE!=0 && ValidD && (RDE==rs1D || (RDE==rs2D && opcode uses rs2)).
- Next-state priority at posedge:
  1. rst==0: clear.
  2. FlushE: bubble.
  3. StallD: bubble.
  4. ValidD==0: bubble.
  5. Otherwise capture the decoded bundle.
- A bubble means all control, ValidE and IllegalE are 0; data fields are don't-care but driven 0.
- Latency: 1 cycle from ID inputs to E outputs.
- A stall lasts exactly 1 cycle: the bubble clears the load condition.
- FlushE together with StallD: flush wins. StallD is still asserted that cycle.
- x0 destination: RDE is carried through; no special casing beyond hazard/bypass exclusion.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants
  - ALUControl codes
  - ResultSrc codes
  - ImmSrc enum {I,S,B,J}
  - the ID/EX bundle field widths
- One sub-module, imm_gen (combinational, ImmSrc + InstrD[31:7] -> ImmExt). The control decoder stays inline.

Test Plan:
- Reset: rst=0 for 2 cycles with a valid add in InstrD -> all E outputs 0, StallD=0; the first cycle after release captures the add.
- addi x5,x0,-1 (0xFFF00293) -> RegWriteE=1, ALUSrcE=1, ImmExtE=0xFFFFFFFF, RDE=5, ALUControlE=000.
- Bypass: add x3,x1,x2 with RegWriteW=1, RDW=1, ResultW=0x1234, RD1=0xAAAA -> RD1E=0x1234, RD2E=RD2. Repeat with RDW=0 -> RD1E=0xAAAA.
- Load-use: lw x4,0(x1) then add x6,x4,x4 -> cycle 2 StallD=1 and a bubble in E; cycle 3 the add is captured with ValidE=1.
- Flush: FlushE=1 while a load-use stall is active -> bubble, and FlushE takes priority.
- Illegal: opcode 0x7F -> IllegalE=1, RegWriteE=MemWriteE=BranchE=JumpE=0, ValidE=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the pipeline stages:
// opcodes, ALU/result codes, immediate formats and the ID/EX bundle.
package riscv_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_src_t;

    typedef struct packed {
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc4;
        logic [IDX_W-1:0]  rs1;
        logic [IDX_W-1:0]  rs2;
        logic [IDX_W-1:0]  rd;
        logic              reg_write;
        logic              mem_write;
        logic [1:0]        result_src;
        logic              alu_src;
        logic              branch;
        logic              jump;
        logic [2:0]        alu_ctrl;
        logic              valid;
        logic              illegal;
    } id_ex_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: rebuilds the sign-extended immediate
// for the I/S/B/J formats from the upper instruction bits.
module imm_gen
    import riscv_pkg::*;
(
    input  imm_src_t    imm_src,
    input  logic [31:7] instr,
    output logic [31:0] imm_ext
);

    // Format-dependent bit scatter, always sign-extended from bit 31
    always_comb begin
        imm_ext = '0;
        unique case (imm_src)
            IMM_I: imm_ext = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm_ext = {{20{instr[31]}}, instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_J: imm_ext = {{12{instr[31]}}, instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: control decode, writeback bypass, load-use stall
// detection and the registered ID/EX bundle.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = DATA_W,
    parameter int REGW = IDX_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            ValidD,
    output logic [REGW-1:0] A1,
    output logic [REGW-1:0] A2,
    input  logic [XLEN-1:0] RD1,
    input  logic [XLEN-1:0] RD2,
    input  logic            RegWriteW,
    input  logic [REGW-1:0] RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            StallD,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [REGW-1:0] RS1E,
    output logic [REGW-1:0] RS2E,
    output logic [REGW-1:0] RDE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            ALUSrcE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [2:0]      ALUControlE,
    output logic            ValidE,
    output logic            IllegalE
);

    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [31:0] imm_ext;
    logic [2:0]  alu_op;
    logic        uses_rs2;
    imm_src_t    imm_src;
    id_ex_t      d;
    id_ex_t      e;

    assign op     = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign A1     = InstrD[19:15];
    assign A2     = InstrD[24:20];

    imm_gen u_imm_gen (
        .imm_src (imm_src),
        .instr   (InstrD[31:7]),
        .imm_ext (imm_ext)
    );

    // ALU operation for R-type and I-ALU from funct3 (sub only on R-type)
    always_comb begin
        alu_op = ALU_ADD;
        unique case (funct3)
            3'b111: alu_op = ALU_AND;
            3'b110: alu_op = ALU_OR;
            3'b010: alu_op = ALU_SLT;
            3'b100: alu_op = ALU_XOR;
            3'b000: alu_op = (op == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
            default: alu_op = ALU_ADD;
        endcase
    end

    // Control decode and next ID/EX bundle, operands bypassed from WB
    always_comb begin
        d          = '0;
        imm_src    = IMM_I;
        uses_rs2   = 1'b0;
        d.pc       = PCD;
        d.pc4      = PCPlus4D;
        d.rs1      = A1;
        d.rs2      = A2;
        d.rd       = InstrD[11:7];
        d.valid    = 1'b1;
        d.rd1      = (RegWriteW && RDW != '0 && RDW == A1) ? ResultW : RD1;
        d.rd2      = (RegWriteW && RDW != '0 && RDW == A2) ? ResultW : RD2;
        unique case (op)
            OP_LW: begin
                d.alu_src    = 1'b1;
                d.result_src = RES_MEM;
                d.reg_write  = 1'b1;
            end
            OP_SW: begin
                imm_src     = IMM_S;
                uses_rs2    = 1'b1;
                d.alu_src   = 1'b1;
                d.mem_write = 1'b1;
            end
            OP_R: begin
                uses_rs2    = 1'b1;
                d.reg_write = 1'b1;
                d.alu_ctrl  = alu_op;
            end
            OP_I: begin
                d.alu_src   = 1'b1;
                d.reg_write = 1'b1;
                d.alu_ctrl  = alu_op;
            end
            OP_BEQ: begin
                imm_src    = IMM_B;
                uses_rs2   = 1'b1;
                d.branch   = 1'b1;
                d.alu_ctrl = ALU_SUB;
            end
            OP_JAL: begin
                imm_src      = IMM_J;
                d.jump       = 1'b1;
                d.result_src = RES_PC4;
                d.reg_write  = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        d.imm = imm_ext;
    end

    // Load in E whose destination the ID instruction reads
    assign StallD = rst && ValidD && e.valid && e.reg_write &&
                    e.result_src == RES_MEM && e.rd != '0 &&
                    (e.rd == A1 || (uses_rs2 && e.rd == A2));

    // ID/EX register: reset, then flush/stall/empty insert a bubble
    always_ff @(posedge clk) begin
        if (!rst)
            e <= '0;
        else if (FlushE || StallD || !ValidD)
            e <= '0;
        else
            e <= d;
    end

    assign RD1E        = e.rd1;
    assign RD2E        = e.rd2;
    assign ImmExtE     = e.imm;
    assign PCE         = e.pc;
    assign PCPlus4E    = e.pc4;
    assign RS1E        = e.rs1;
    assign RS2E        = e.rs2;
    assign RDE         = e.rd;
    assign RegWriteE   = e.reg_write;
    assign MemWriteE   = e.mem_write;
    assign ResultSrcE  = e.result_src;
    assign ALUSrcE     = e.alu_src;
    assign BranchE     = e.branch;
    assign JumpE       = e.jump;
    assign ALUControlE = e.alu_ctrl;
    assign ValidE      = e.valid;
    assign IllegalE    = e.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: behavioural model checked every
// negedge, plus directed vectors with literal expectations.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;
    logic        StallD;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RS1E, RS2E, RDE;
    logic        RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic        ALUSrcE, BranchE, JumpE;
    logic [2:0]  ALUControlE;
    logic        ValidE, IllegalE;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .A1(A1), .A2(A2),
        .RD1(RD1), .RD2(RD2), .RegWriteW(RegWriteW), .RDW(RDW),
        .ResultW(ResultW), .FlushE(FlushE), .StallD(StallD),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
        .JumpE(JumpE), .ALUControlE(ALUControlE), .ValidE(ValidE),
        .IllegalE(IllegalE)
    );

    typedef struct packed {
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mw;
        logic [1:0]  rs;
        logic        as, br, jp;
        logic [2:0]  alu;
        logic        v, il, care_imm;
    } exp_t;

    exp_t        m = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] pc = 32'h0000_1000;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate value computed arithmetically from the field layout
    function automatic logic [31:0] imm_of(input logic [31:0] i, input int k);
        int s;
        s = $signed(i) >>> 31;
        case (k)
            0: return $signed(i) >>> 20;
            1: return s * 2048 + int'(i[30:25]) * 32 + int'(i[11:7]);
            2: return s * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                      + int'(i[11:8]) * 2;
            default: return s * 1048576 + int'(i[19:12]) * 4096
                      + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        endcase
    endfunction

    function automatic exp_t decode(input logic [31:0] i);
        exp_t       e;
        logic [2:0] ftab [8];
        ftab = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd4, 3'd0, 3'd3, 3'd2};
        e = '0;
        e.v = 1'b1;
        e.pc = PCD;
        e.pc4 = PCPlus4D;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd = i[11:7];
        e.rd1 = (RegWriteW && RDW != 0 && RDW == i[19:15]) ? ResultW : RD1;
        e.rd2 = (RegWriteW && RDW != 0 && RDW == i[24:20]) ? ResultW : RD2;
        case (i[6:0])
            7'h03: begin e.imm = imm_of(i, 0); e.care_imm = 1; e.as = 1;
                         e.rs = 2'b01; e.rw = 1; end
            7'h23: begin e.imm = imm_of(i, 1); e.care_imm = 1; e.as = 1;
                         e.mw = 1; end
            7'h33: begin e.rw = 1;
                         e.alu = (i[14:12] == 0 && i[30]) ? 3'd1 : ftab[i[14:12]];
                   end
            7'h13: begin e.imm = imm_of(i, 0); e.care_imm = 1; e.as = 1;
                         e.rw = 1; e.alu = ftab[i[14:12]]; end
            7'h63: begin e.imm = imm_of(i, 2); e.care_imm = 1; e.br = 1;
                         e.alu = 3'd1; end
            7'h6F: begin e.imm = imm_of(i, 3); e.care_imm = 1; e.jp = 1;
                         e.rs = 2'b10; e.rw = 1; end
            default: e.il = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic model_stall();
        logic reads_rs2;
        reads_rs2 = InstrD[6:0] inside {7'h33, 7'h23, 7'h63};
        return rst && ValidD && m.v && m.rw && m.rs == 2'b01 && m.rd != 0 &&
               (m.rd == InstrD[19:15] || (reads_rs2 && m.rd == InstrD[24:20]));
    endfunction

    // Model update: what E must hold after each edge
    always @(posedge clk) begin
        logic st;
        st = model_stall();
        if (!rst || FlushE || st || !ValidD)
            m = '0;
        else
            m = decode(InstrD);
    end

    // Compare process
    always @(negedge clk) begin
        chk("StallD", 32'(StallD), 32'(model_stall()));
        chk("ValidE", 32'(ValidE), 32'(m.v));
        chk("IllegalE", 32'(IllegalE), 32'(m.il));
        chk("RegWriteE", 32'(RegWriteE), 32'(m.rw));
        chk("MemWriteE", 32'(MemWriteE), 32'(m.mw));
        chk("ResultSrcE", 32'(ResultSrcE), 32'(m.rs));
        chk("ALUSrcE", 32'(ALUSrcE), 32'(m.as));
        chk("BranchE", 32'(BranchE), 32'(m.br));
        chk("JumpE", 32'(JumpE), 32'(m.jp));
        chk("RDE", 32'(RDE), 32'(m.rd));
        chk("RS1E", 32'(RS1E), 32'(m.rs1));
        chk("RS2E", 32'(RS2E), 32'(m.rs2));
        chk("PCE", PCE, m.pc);
        chk("PCPlus4E", PCPlus4E, m.pc4);
        chk("RD1E", RD1E, m.rd1);
        chk("RD2E", RD2E, m.rd2);
        if (!m.v || m.care_imm) chk("ImmExtE", ImmExtE, m.imm);
        if (!m.v || !m.il) chk("ALUControlE", 32'(ALUControlE), 32'(m.alu));
    end

    task automatic drive(input logic [31:0] instr, input logic v = 1'b1);
        InstrD = instr;
        ValidD = v;
        PCD = pc;
        PCPlus4D = pc + 32'd4;
        pc = pc + 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    localparam logic [31:0] ADD_3_1_2  = 32'h0020_81B3;
    localparam logic [31:0] ADDI_5_M1  = 32'hFFF0_0293;
    localparam logic [31:0] LW_4       = 32'h0000_A203;
    localparam logic [31:0] LW_0       = 32'h0000_A003;
    localparam logic [31:0] ADD_6_4_4  = 32'h0042_0333;
    localparam logic [31:0] ADD_6_0_0  = 32'h0000_0333;
    localparam logic [31:0] ADDI_6_1_4 = 32'h0040_8313;
    localparam logic [31:0] SW_2_8     = 32'h0020_A423;
    localparam logic [31:0] BEQ_M4     = 32'hFE20_8EE3;
    localparam logic [31:0] JAL_800    = 32'h0010_00EF;
    localparam logic [31:0] SUB_7_1_2  = 32'h4020_83B3;
    localparam logic [31:0] ILLEGAL    = 32'h0000_007F;

    initial begin
        logic [31:0] rtab [4];
        rtab = '{32'h0020_F3B3, 32'h0020_E3B3, 32'h0020_C3B3, 32'h0020_A3B3};
        rst = 1'b0; FlushE = 1'b0;
        RD1 = 32'h0000_AAAA; RD2 = 32'h0000_BBBB;
        RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0;
        drive(ADD_3_1_2);
        tick(); tick();
        chk("rst ValidE", 32'(ValidE), 32'd0);
        chk("rst RegWriteE", 32'(RegWriteE), 32'd0);
        chk("rst StallD", 32'(StallD), 32'd0);
        rst = 1'b1;
        tick();
        chk("post-rst ValidE", 32'(ValidE), 32'd1);
        chk("post-rst RDE", 32'(RDE), 32'd3);

        drive(ADDI_5_M1); tick();
        chk("addi ImmExtE", ImmExtE, 32'hFFFF_FFFF);
        chk("addi RDE", 32'(RDE), 32'd5);
        chk("addi ALUSrcE", 32'(ALUSrcE), 32'd1);
        chk("addi ALUControlE", 32'(ALUControlE), 32'd0);

        drive(ADD_3_1_2);
        RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'h0000_1234; tick();
        chk("bypass RD1E", RD1E, 32'h0000_1234);
        chk("bypass RD2E", RD2E, 32'h0000_BBBB);
        drive(ADD_3_1_2); RDW = 5'd0; tick();
        chk("x0 no-bypass RD1E", RD1E, 32'h0000_AAAA);
        drive(ADD_3_1_2); RDW = 5'd2; tick();
        chk("bypass RD2E", RD2E, 32'h0000_1234);
        drive(ADD_3_1_2); RegWriteW = 1'b0; tick();
        chk("no-we RD2E", RD2E, 32'h0000_BBBB);

        drive(LW_4); tick();
        chk("lw ResultSrcE", 32'(ResultSrcE), 32'd1);
        drive(ADD_6_4_4); #1;
        chk("load-use StallD", 32'(StallD), 32'd1);
        tick();
        chk("stall bubble ValidE", 32'(ValidE), 32'd0);
        #1 chk("stall cleared", 32'(StallD), 32'd0);
        tick();
        chk("after stall ValidE", 32'(ValidE), 32'd1);
        chk("after stall RDE", 32'(RDE), 32'd6);

        drive(LW_4); tick();
        drive(ADD_6_4_4); FlushE = 1'b1; #1;
        chk("flush+stall StallD", 32'(StallD), 32'd1);
        tick(); FlushE = 1'b0;
        chk("flush bubble ValidE", 32'(ValidE), 32'd0);
        tick();
        chk("after flush ValidE", 32'(ValidE), 32'd1);
        drive(ADDI_5_M1); FlushE = 1'b1; tick(); FlushE = 1'b0;
        chk("flush only ValidE", 32'(ValidE), 32'd0);

        drive(LW_4); tick();
        drive(ADDI_6_1_4); #1;
        chk("I-type rs2 no stall", 32'(StallD), 32'd0);
        tick();
        drive(LW_0); tick();
        drive(ADD_6_0_0); #1;
        chk("x0 load no stall", 32'(StallD), 32'd0);
        tick();
        drive(LW_4); tick();
        drive(ADD_6_4_4); rst = 1'b0; #1;
        chk("rst forces StallD", 32'(StallD), 32'd0);
        tick(); rst = 1'b1;
        chk("rst bubble ValidE", 32'(ValidE), 32'd0);

        drive(ILLEGAL); tick();
        chk("illegal IllegalE", 32'(IllegalE), 32'd1);
        chk("illegal ValidE", 32'(ValidE), 32'd1);
        chk("illegal enables",
            32'({RegWriteE, MemWriteE, BranchE, JumpE}), 32'd0);
        drive(SW_2_8); tick();
        chk("sw ImmExtE", ImmExtE, 32'd8);
        chk("sw MemWriteE", 32'(MemWriteE), 32'd1);
        drive(BEQ_M4); tick();
        chk("beq ImmExtE", ImmExtE, 32'hFFFF_FFFC);
        chk("beq ALUControlE", 32'(ALUControlE), 32'd1);
        drive(JAL_800); tick();
        chk("jal ImmExtE", ImmExtE, 32'h0000_0800);
        chk("jal ResultSrcE", 32'(ResultSrcE), 32'd2);
        drive(SUB_7_1_2); tick();
        chk("sub ALUControlE", 32'(ALUControlE), 32'd1);
        foreach (rtab[k]) begin
            drive(rtab[k]); tick();
        end
        drive(ADD_3_1_2, 1'b0); tick();
        chk("invalid ValidE", 32'(ValidE), 32'd0);
        drive(JAL_800); tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
